// File: rtl/single_cycle_pkg.sv
// Shared definitions for the single-cycle MIPS-subset core: opcodes,
// R-type function codes, ALU operations and the decoded control bundle.
package single_cycle_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  // Link register written by jal
  localparam logic [4:0] REG_RA = 5'd31;

  typedef enum logic [2:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, ALU_SLL, ALU_SRL, ALU_LUI
  } alu_op_t;

  typedef enum logic [1:0] {DST_RT, DST_RD, DST_RA} dst_sel_t;

  typedef enum logic [1:0] {WB_ALU, WB_MEM, WB_LINK} wb_sel_t;

  typedef struct packed {
    logic     regWrite;
    dst_sel_t dst;
    wb_sel_t  wb;
    logic     memWrite;
    logic     aluSrcImm;
    logic     immZero;
    alu_op_t  aluOp;
    logic     branchEq;
    logic     branchNe;
    logic     jump;
    logic     jumpReg;
  } ctrl_t;

endpackage

// File: rtl/single_cycle_datapath.sv
// Datapath of the single-cycle core: PC register, instruction memory,
// register file, ALU, data memory and next-PC selection. Control comes
// from the combinational decoder in the top level.

// Program counter register; clears to 0 the moment reset is asserted.
module single_cycle_pc (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pcNext,
  output logic [31:0] value
);
  logic [31:0] PC;

  // Advance to the selected next PC every cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) PC <= 32'h0;
    else        PC <= pcNext;
  end

  assign value = PC;
endmodule

// Instruction memory: contents preloaded from a hex image, read-only here.
module single_cycle_imem #(
  parameter  int WORDS = 256,
  localparam int AW    = $clog2(WORDS)
) (
  input  logic [AW-1:0] index,
  output logic [31:0]   rdata
);
  reg [31:0] RAM [0:WORDS-1];

  assign rdata = RAM[index];
endmodule

// Data memory: combinational read, write on the rising edge, no reset.
module single_cycle_dmem #(
  parameter  int WORDS = 256,
  localparam int AW    = $clog2(WORDS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] index,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);
  reg [31:0] RAM [0:WORDS-1];

  // Store the word addressed by the current sw
  always_ff @(posedge clk) begin
    if (we) RAM[index] <= wdata;
  end

  assign rdata = RAM[index];
endmodule

module single_cycle_datapath
  import single_cycle_pkg::*;
#(
  parameter int IMEM_WORDS = 256,
  parameter int DMEM_WORDS = 256
) (
  input  logic       clk,
  input  logic       reset,
  input  ctrl_t      ctrl,
  output logic [5:0] opcode,
  output logic [5:0] funct
);
  localparam int IAW = $clog2(IMEM_WORDS);
  localparam int DAW = $clog2(DMEM_WORDS);

  logic [31:0]      pcCur;
  logic [31:0]      pcNext;
  logic [31:0]      pcPlus4;
  logic [31:0]      instr;
  logic [4:0]       rs, rt, rd, shamt;
  logic [15:0]      imm;
  logic [31:0]      immSext;
  logic [31:0]      immExt;
  logic [31:0]      rsVal, rtVal;
  logic [31:0]      aluB;
  logic [31:0]      aluResult;
  logic [31:0]      memRdata;
  logic [31:0]      wbData;
  logic [4:0]       wrAddr;
  logic             branchTaken;
  logic [31:0][31:0] rf;

  single_cycle_pc PC (
    .clk    (clk),
    .reset  (reset),
    .pcNext (pcNext),
    .value  (pcCur)
  );

  // Byte PC; the low two bits are ignored and the word index wraps
  single_cycle_imem #(.WORDS(IMEM_WORDS)) insructionMemory (
    .index (pcCur[IAW+1:2]),
    .rdata (instr)
  );

  assign opcode  = instr[31:26];
  assign funct   = instr[5:0];
  assign rs      = instr[25:21];
  assign rt      = instr[20:16];
  assign rd      = instr[15:11];
  assign shamt   = instr[10:6];
  assign imm     = instr[15:0];
  assign immSext = {{16{imm[15]}}, imm};
  assign immExt  = ctrl.immZero ? {16'h0, imm} : immSext;
  assign pcPlus4 = pcCur + 32'd4;

  assign rsVal = (rs == 5'd0) ? 32'h0 : rf[rs];
  assign rtVal = (rt == 5'd0) ? 32'h0 : rf[rt];
  assign aluB  = ctrl.aluSrcImm ? immExt : rtVal;

  // ALU; shifts act on rt by shamt, lui places the immediate in the top half
  always_comb begin
    aluResult = 32'h0;
    case (ctrl.aluOp)
      ALU_ADD: aluResult = rsVal + aluB;
      ALU_SUB: aluResult = rsVal - aluB;
      ALU_AND: aluResult = rsVal & aluB;
      ALU_OR:  aluResult = rsVal | aluB;
      ALU_SLT: aluResult = {31'b0, $signed(rsVal) < $signed(aluB)};
      ALU_SLL: aluResult = aluB << shamt;
      ALU_SRL: aluResult = aluB >> shamt;
      ALU_LUI: aluResult = {aluB[15:0], 16'h0};
      default: aluResult = rsVal + aluB;
    endcase
  end

  // Stores are suppressed while reset is held so DMEM survives an abort
  single_cycle_dmem #(.WORDS(DMEM_WORDS)) MemoryData (
    .clk   (clk),
    .we    (ctrl.memWrite && reset),
    .index (aluResult[DAW+1:2]),
    .wdata (rtVal),
    .rdata (memRdata)
  );

  // Pick destination register and write-back source
  always_comb begin
    wrAddr = rt;
    wbData = aluResult;
    case (ctrl.dst)
      DST_RD:  wrAddr = rd;
      DST_RA:  wrAddr = REG_RA;
      default: wrAddr = rt;
    endcase
    case (ctrl.wb)
      WB_MEM:  wbData = memRdata;
      WB_LINK: wbData = pcPlus4;
      default: wbData = aluResult;
    endcase
  end

  assign branchTaken = (ctrl.branchEq && (rsVal == rtVal)) ||
                       (ctrl.branchNe && (rsVal != rtVal));

  // Next PC: jr, then j/jal, then taken branch, otherwise fall through
  always_comb begin
    pcNext = pcPlus4;
    if (ctrl.jumpReg)   pcNext = rsVal;
    else if (ctrl.jump) pcNext = {pcPlus4[31:28], instr[25:0], 2'b00};
    else if (branchTaken) pcNext = pcPlus4 + {immSext[29:0], 2'b00};
  end

  // Register file write; r0 is never written so it always reads zero
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rf <= '0;
    else if (ctrl.regWrite && (wrAddr != 5'd0)) rf[wrAddr] <= wbData;
  end

endmodule

// File: rtl/single_cycle.sv
// Top of the single-cycle MIPS-subset core: combinational control decoder
// driving the datapath, one instruction retired per clock.
module single_cycle
  import single_cycle_pkg::*;
#(
  parameter int IMEM_WORDS = 256,
  parameter int DMEM_WORDS = 256
) (
  input logic clk,
  input logic reset
);
  logic [5:0] opcode;
  logic [5:0] funct;
  ctrl_t      ctrl;

  // Decode opcode/funct into datapath controls; unknown encodings are no-ops
  always_comb begin
    ctrl.regWrite  = 1'b0;
    ctrl.dst       = DST_RT;
    ctrl.wb        = WB_ALU;
    ctrl.memWrite  = 1'b0;
    ctrl.aluSrcImm = 1'b0;
    ctrl.immZero   = 1'b0;
    ctrl.aluOp     = ALU_ADD;
    ctrl.branchEq  = 1'b0;
    ctrl.branchNe  = 1'b0;
    ctrl.jump      = 1'b0;
    ctrl.jumpReg   = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        ctrl.dst = DST_RD;
        case (funct)
          FN_ADD: begin ctrl.regWrite = 1'b1; ctrl.aluOp = ALU_ADD; end
          FN_SUB: begin ctrl.regWrite = 1'b1; ctrl.aluOp = ALU_SUB; end
          FN_AND: begin ctrl.regWrite = 1'b1; ctrl.aluOp = ALU_AND; end
          FN_OR:  begin ctrl.regWrite = 1'b1; ctrl.aluOp = ALU_OR;  end
          FN_SLT: begin ctrl.regWrite = 1'b1; ctrl.aluOp = ALU_SLT; end
          FN_SLL: begin ctrl.regWrite = 1'b1; ctrl.aluOp = ALU_SLL; end
          FN_SRL: begin ctrl.regWrite = 1'b1; ctrl.aluOp = ALU_SRL; end
          FN_JR:  ctrl.jumpReg = 1'b1;
          default: ;
        endcase
      end
      OP_ADDI: begin
        ctrl.regWrite = 1'b1; ctrl.aluSrcImm = 1'b1; ctrl.aluOp = ALU_ADD;
      end
      OP_SLTI: begin
        ctrl.regWrite = 1'b1; ctrl.aluSrcImm = 1'b1; ctrl.aluOp = ALU_SLT;
      end
      OP_ANDI: begin
        ctrl.regWrite = 1'b1; ctrl.aluSrcImm = 1'b1; ctrl.immZero = 1'b1;
        ctrl.aluOp = ALU_AND;
      end
      OP_ORI: begin
        ctrl.regWrite = 1'b1; ctrl.aluSrcImm = 1'b1; ctrl.immZero = 1'b1;
        ctrl.aluOp = ALU_OR;
      end
      OP_LUI: begin
        ctrl.regWrite = 1'b1; ctrl.aluSrcImm = 1'b1; ctrl.aluOp = ALU_LUI;
      end
      OP_LW: begin
        ctrl.regWrite = 1'b1; ctrl.aluSrcImm = 1'b1; ctrl.wb = WB_MEM;
      end
      OP_SW: begin
        ctrl.memWrite = 1'b1; ctrl.aluSrcImm = 1'b1;
      end
      OP_BEQ: ctrl.branchEq = 1'b1;
      OP_BNE: ctrl.branchNe = 1'b1;
      OP_J:   ctrl.jump = 1'b1;
      OP_JAL: begin
        ctrl.jump = 1'b1; ctrl.regWrite = 1'b1; ctrl.dst = DST_RA;
        ctrl.wb = WB_LINK;
      end
      default: ;
    endcase
  end

  single_cycle_datapath #(
    .IMEM_WORDS (IMEM_WORDS),
    .DMEM_WORDS (DMEM_WORDS)
  ) datapath (
    .clk    (clk),
    .reset  (reset),
    .ctrl   (ctrl),
    .opcode (opcode),
    .funct  (funct)
  );

endmodule

// File: tb/tb_single_cycle.sv
// Testbench for single_cycle: directed programs plus random instruction
// streams checked against an instruction-level reference model.
module tb_single_cycle;

  logic clk;
  logic reset;
  int   testsRun;
  int   testsFailed;

  logic [31:0] progArr [256];
  logic [31:0] mImem [256];
  logic [31:0] mMem [256];
  logic [31:0] mReg [32];
  logic [31:0] mPc;

  single_cycle #(.IMEM_WORDS(256), .DMEM_WORDS(256)) dut (
    .clk   (clk),
    .reset (reset)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] encR(int fn, int rs, int rt, int rd, int sh);
    return {6'h00, rs[4:0], rt[4:0], rd[4:0], sh[4:0], fn[5:0]};
  endfunction

  function automatic logic [31:0] encI(int op, int rs, int rt, int imm);
    return {op[5:0], rs[4:0], rt[4:0], imm[15:0]};
  endfunction

  function automatic logic [31:0] encJ(int op, int target);
    return {op[5:0], target[25:0]};
  endfunction

  task automatic clearProg();
    for (int i = 0; i < 256; i++) progArr[i] = 32'h0;
  endtask

  // Copy the program into IMEM (and the model); optionally randomise DMEM
  task automatic loadImage(input bit randomDmem);
    logic [31:0] v;
    for (int i = 0; i < 256; i++) begin
      dut.datapath.insructionMemory.RAM[i] = progArr[i];
      mImem[i] = progArr[i];
      if (randomDmem) begin
        v = $urandom();
        dut.datapath.MemoryData.RAM[i] = v;
        mMem[i] = v;
      end
    end
    for (int i = 0; i < 32; i++) mReg[i] = 32'h0;
    mPc = 32'h0;
  endtask

  task automatic resetAndLoad(input bit randomDmem);
    @(negedge clk);
    reset = 1'b0;
    loadImage(randomDmem);
    repeat (3) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic wreg(input logic [4:0] r, input logic [31:0] v);
    if (r != 5'd0) mReg[r] = v;
  endtask

  // Reference model: execute one instruction at the architectural level
  task automatic modelStep();
    logic [31:0] w, a, b, se, ze, pc4, addr, npc;
    logic [5:0]  op, fn;
    logic [4:0]  rs, rt, rd, sh;
    w  = mImem[mPc[9:2]];
    op = w[31:26]; rs = w[25:21]; rt = w[20:16]; rd = w[15:11];
    sh = w[10:6];  fn = w[5:0];
    a = mReg[rs]; b = mReg[rt];
    se = {{16{w[15]}}, w[15:0]};
    ze = {16'h0, w[15:0]};
    pc4 = mPc + 32'd4;
    npc = pc4;
    addr = a + se;
    case (op)
      6'h00: case (fn)
        6'h20: wreg(rd, a + b);
        6'h22: wreg(rd, a - b);
        6'h24: wreg(rd, a & b);
        6'h25: wreg(rd, a | b);
        6'h2A: wreg(rd, ($signed(a) < $signed(b)) ? 32'd1 : 32'd0);
        6'h00: wreg(rd, b << sh);
        6'h02: wreg(rd, b >> sh);
        6'h08: npc = a;
        default: ;
      endcase
      6'h08: wreg(rt, a + se);
      6'h0A: wreg(rt, ($signed(a) < $signed(se)) ? 32'd1 : 32'd0);
      6'h0C: wreg(rt, a & ze);
      6'h0D: wreg(rt, a | ze);
      6'h0F: wreg(rt, {w[15:0], 16'h0});
      6'h23: wreg(rt, mMem[addr[9:2]]);
      6'h2B: mMem[addr[9:2]] = b;
      6'h04: if (a == b) npc = pc4 + (se << 2);
      6'h05: if (a != b) npc = pc4 + (se << 2);
      6'h02: npc = {pc4[31:28], w[25:0], 2'b00};
      6'h03: begin npc = {pc4[31:28], w[25:0], 2'b00}; wreg(5'd31, pc4); end
      default: ;
    endcase
    mPc = npc;
  endtask

  function automatic logic [31:0] randInstr();
    int k, rs, rt, rd, sh, imm, off;
    k   = int'($urandom_range(0, 21));
    rs  = int'($urandom_range(0, 7));
    rt  = int'($urandom_range(0, 7));
    rd  = int'($urandom_range(0, 7));
    sh  = int'($urandom_range(0, 31));
    imm = int'($urandom_range(0, 65535));
    off = int'($urandom_range(0, 12)) - 4;
    case (k)
      0:  return encR('h20, rs, rt, rd, 0);
      1:  return encR('h22, rs, rt, rd, 0);
      2:  return encR('h24, rs, rt, rd, 0);
      3:  return encR('h25, rs, rt, rd, 0);
      4:  return encR('h2A, rs, rt, rd, 0);
      5:  return encR('h00, 0, rt, rd, sh);
      6:  return encR('h02, 0, rt, rd, sh);
      7:  return encI('h08, rs, rt, imm);
      8:  return encI('h0A, rs, rt, imm);
      9:  return encI('h0C, rs, rt, imm);
      10: return encI('h0D, rs, rt, imm);
      11: return encI('h0F, 0, rt, imm);
      12, 13: return encI('h23, rs, rt, imm);
      14, 15: return encI('h2B, rs, rt, imm);
      16: return encI('h04, rs, rt, off);
      17: return encI('h05, rs, rt, off);
      18: return encJ(int'($urandom_range(2, 3)), int'($urandom_range(0, 255)));
      19: return encR('h08, rs, 0, 0, 0);
      20: return encI('h3F, rs, rt, imm);
      default: return encR('h3F, rs, rt, rd, sh);
    endcase
  endfunction

  task automatic buildSortProg();
    clearProg();
    progArr[0]  = encI('h08, 0, 1, 'h80);
    progArr[1]  = encI('h08, 0, 2, 'h84);
    progArr[2]  = encI('h08, 0, 3, 'h100);
    progArr[3]  = encI('h04, 2, 3, 26);
    progArr[4]  = encI('h23, 2, 4, 0);
    progArr[5]  = encI('h08, 2, 5, -4);
    progArr[6]  = encR('h2A, 5, 1, 6, 0);
    progArr[7]  = encI('h05, 6, 0, 6);
    progArr[8]  = encI('h23, 5, 7, 0);
    progArr[9]  = encR('h2A, 4, 7, 6, 0);
    progArr[10] = encI('h04, 6, 0, 3);
    progArr[11] = encI('h2B, 5, 7, 4);
    progArr[12] = encI('h08, 5, 5, -4);
    progArr[13] = encJ('h02, 6);
    progArr[14] = encI('h2B, 5, 4, 4);
    progArr[15] = encI('h08, 2, 2, 4);
    progArr[16] = encJ('h02, 3);
    progArr[30] = encJ('h02, 'h1E);
  endtask

  task automatic test_reset();
    clearProg();
    @(negedge clk);
    reset = 1'b0;
    loadImage(1'b0);
    repeat (3) @(posedge clk);
    #1;
    testsRun++;
    if (dut.datapath.PC.PC !== 32'h0) begin
      testsFailed++;
      $display("[TB] FAIL reset_pc: got %h expected 00000000", dut.datapath.PC.PC);
    end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    testsRun++;
    if (dut.datapath.PC.PC !== 32'h4) begin
      testsFailed++;
      $display("[TB] FAIL reset_first_edge_pc: got %h expected 00000004", dut.datapath.PC.PC);
    end
    for (int r = 1; r < 32; r++) begin
      testsRun++;
      if (dut.datapath.rf[r] !== 32'h0) begin
        testsFailed++;
        $display("[TB] FAIL reset_reg r%0d: got %h expected 00000000", r, dut.datapath.rf[r]);
      end
    end
  endtask

  task automatic test_alu();
    logic [31:0] expv [6];
    clearProg();
    progArr[0] = encI('h08, 0, 1, 5);
    progArr[1] = encI('h08, 0, 2, -3);
    progArr[2] = encR('h20, 1, 2, 3, 0);
    progArr[3] = encR('h2A, 2, 1, 4, 0);
    progArr[4] = encR('h22, 2, 1, 5, 0);
    resetAndLoad(1'b1);
    expv = '{32'h0, 32'd5, 32'hFFFFFFFD, 32'd2, 32'd1, 32'hFFFFFFF8};
    repeat (5) @(posedge clk);
    #1;
    for (int r = 1; r < 6; r++) begin
      testsRun++;
      if (dut.datapath.rf[r] !== expv[r]) begin
        testsFailed++;
        $display("[TB] FAIL alu_r%0d: got %h expected %h", r, dut.datapath.rf[r], expv[r]);
      end
    end
  endtask

  task automatic test_memory();
    clearProg();
    progArr[0] = encI('h08, 0, 1, 'h80);
    progArr[1] = encI('h08, 0, 2, 'h1234);
    progArr[2] = encI('h2B, 1, 2, 4);
    progArr[3] = encI('h23, 1, 3, 4);
    progArr[4] = encI('h08, 0, 0, 7);
    resetAndLoad(1'b1);
    repeat (5) @(posedge clk);
    #1;
    testsRun++;
    if (dut.datapath.MemoryData.RAM[33] !== 32'h1234) begin
      testsFailed++;
      $display("[TB] FAIL mem_store: got %h expected 00001234", dut.datapath.MemoryData.RAM[33]);
    end
    testsRun++;
    if (dut.datapath.rf[3] !== 32'h1234) begin
      testsFailed++;
      $display("[TB] FAIL mem_load: got %h expected 00001234", dut.datapath.rf[3]);
    end
    testsRun++;
    if (dut.datapath.rf[0] !== 32'h0) begin
      testsFailed++;
      $display("[TB] FAIL mem_r0: got %h expected 00000000", dut.datapath.rf[0]);
    end
  endtask

  task automatic test_control();
    logic [31:0] expPc [4];
    clearProg();
    progArr[0]  = encI('h08, 0, 1, 1);
    progArr[1]  = encI('h08, 0, 2, 1);
    progArr[4]  = encI('h04, 1, 2, 2);
    progArr[7]  = encI('h05, 1, 2, 5);
    progArr[8]  = encJ('h03, 'h20);
    progArr[32] = encR('h08, 31, 0, 0, 0);
    resetAndLoad(1'b1);
    expPc = '{32'h1C, 32'h20, 32'h80, 32'h24};
    repeat (4) @(posedge clk);
    for (int s = 0; s < 4; s++) begin
      @(posedge clk);
      #1;
      testsRun++;
      if (dut.datapath.PC.PC !== expPc[s]) begin
        testsFailed++;
        $display("[TB] FAIL control_pc step %0d: got %h expected %h", s, dut.datapath.PC.PC, expPc[s]);
      end
      if (s == 2) begin
        testsRun++;
        if (dut.datapath.rf[31] !== 32'h24) begin
          testsFailed++;
          $display("[TB] FAIL control_jal_link: got %h expected 00000024", dut.datapath.rf[31]);
        end
      end
    end
  endtask

  task automatic test_random();
    int  regBad;
    int  memBad;
    bit  diverged;
    for (int round = 0; round < 3; round++) begin
      for (int i = 0; i < 256; i++) progArr[i] = randInstr();
      resetAndLoad(1'b1);
      diverged = 1'b0;
      for (int c = 0; c < 300 && !diverged; c++) begin
        @(posedge clk);
        modelStep();
        #1;
        testsRun++;
        if (dut.datapath.PC.PC !== mPc) begin
          testsFailed++;
          diverged = 1'b1;
          $display("[TB] FAIL random_pc round %0d cycle %0d: got %h expected %h", round, c, dut.datapath.PC.PC, mPc);
        end
        regBad = -1;
        for (int r = 0; r < 32; r++)
          if (regBad < 0 && dut.datapath.rf[r] !== mReg[r]) regBad = r;
        testsRun++;
        if (regBad >= 0) begin
          testsFailed++;
          diverged = 1'b1;
          $display("[TB] FAIL random_reg round %0d cycle %0d r%0d: got %h expected %h", round, c, regBad, dut.datapath.rf[regBad], mReg[regBad]);
        end
      end
      memBad = -1;
      for (int i = 0; i < 256; i++)
        if (memBad < 0 && dut.datapath.MemoryData.RAM[i] !== mMem[i]) memBad = i;
      testsRun++;
      if (memBad >= 0) begin
        testsFailed++;
        $display("[TB] FAIL random_dmem round %0d word %0d: got %h expected %h", round, memBad, dut.datapath.MemoryData.RAM[memBad], mMem[memBad]);
      end
    end
  endtask

  task automatic test_sort();
    int          expSorted [32];
    int          tmp;
    int          cycles;
    logic [31:0] orig [256];
    buildSortProg();
    resetAndLoad(1'b1);
    for (int i = 0; i < 256; i++) orig[i] = mMem[i];
    for (int i = 0; i < 32; i++) expSorted[i] = int'(orig[32 + i]);
    for (int i = 0; i < 32; i++)
      for (int j = 0; j < 31 - i; j++)
        if (expSorted[j] > expSorted[j + 1]) begin
          tmp = expSorted[j];
          expSorted[j] = expSorted[j + 1];
          expSorted[j + 1] = tmp;
        end
    cycles = 0;
    do begin
      @(posedge clk);
      #1;
      cycles++;
    end while (dut.datapath.PC.PC !== 32'h78 && cycles < 20000);
    testsRun++;
    if (dut.datapath.PC.PC !== 32'h78) begin
      testsFailed++;
      $display("[TB] FAIL sort_halt: pc %h expected 00000078 after %0d cycles", dut.datapath.PC.PC, cycles);
    end
    for (int i = 0; i < 32; i++) begin
      testsRun++;
      if (dut.datapath.MemoryData.RAM[32 + i] !== 32'(expSorted[i])) begin
        testsFailed++;
        $display("[TB] FAIL sort_word %0d: got %h expected %h", 32 + i, dut.datapath.MemoryData.RAM[32 + i], 32'(expSorted[i]));
      end
    end
    for (int i = 64; i < 128; i++) begin
      testsRun++;
      if (dut.datapath.MemoryData.RAM[i] !== orig[i]) begin
        testsFailed++;
        $display("[TB] FAIL sort_untouched %0d: got %h expected %h", i, dut.datapath.MemoryData.RAM[i], orig[i]);
      end
    end
  endtask

  task automatic test_async_reset();
    int  k;
    int  cycles;
    int  regBad;
    bit  diverged;
    buildSortProg();
    resetAndLoad(1'b1);
    k = int'($urandom_range(150, 600));
    diverged = 1'b0;
    for (int c = 0; c < k; c++) begin
      @(posedge clk);
      modelStep();
      #1;
      if (!diverged) begin
        testsRun++;
        if (dut.datapath.PC.PC !== mPc) begin
          testsFailed++;
          diverged = 1'b1;
          $display("[TB] FAIL abort_prerun_pc cycle %0d: got %h expected %h", c, dut.datapath.PC.PC, mPc);
        end
      end
    end
    #2;
    reset = 1'b0;
    #1;
    testsRun++;
    if (dut.datapath.PC.PC !== 32'h0) begin
      testsFailed++;
      $display("[TB] FAIL abort_pc_immediate: got %h expected 00000000", dut.datapath.PC.PC);
    end
    regBad = -1;
    for (int r = 0; r < 32; r++)
      if (regBad < 0 && dut.datapath.rf[r] !== 32'h0) regBad = r;
    testsRun++;
    if (regBad >= 0) begin
      testsFailed++;
      $display("[TB] FAIL abort_regs_clear r%0d: got %h expected 00000000", regBad, dut.datapath.rf[regBad]);
    end
    for (int r = 0; r < 32; r++) mReg[r] = 32'h0;
    mPc = 32'h0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    modelStep();
    #1;
    testsRun++;
    if (dut.datapath.PC.PC !== 32'h4) begin
      testsFailed++;
      $display("[TB] FAIL abort_restart_pc: got %h expected 00000004", dut.datapath.PC.PC);
    end
    cycles = 0;
    while (mPc !== 32'h78 && cycles < 20000) begin
      @(posedge clk);
      modelStep();
      #1;
      cycles++;
    end
    testsRun++;
    if (dut.datapath.PC.PC !== mPc) begin
      testsFailed++;
      $display("[TB] FAIL abort_final_pc: got %h expected %h", dut.datapath.PC.PC, mPc);
    end
    for (int i = 32; i < 128; i++) begin
      testsRun++;
      if (dut.datapath.MemoryData.RAM[i] !== mMem[i]) begin
        testsFailed++;
        $display("[TB] FAIL abort_dmem %0d: got %h expected %h", i, dut.datapath.MemoryData.RAM[i], mMem[i]);
      end
    end
  endtask

  initial begin
    reset       = 1'b0;
    testsRun    = 0;
    testsFailed = 0;
    test_reset();
    test_alu();
    test_memory();
    test_control();
    test_random();
    test_sort();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
